// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if -- request/response bus between a bus master and mem_sequencer.
//
// Signals:
//   req_valid  master -> seq  request present
//   req_ready  seq -> master  sequencer can accept a request
//   req_we     master -> seq  1 = write, 0 = read
//   req_addr   master -> seq  16-bit word address
//   req_wdata  master -> seq  16-bit write data
//   req_be     master -> seq  byte enables {upper, lower}
//   resp_valid seq -> master  one-cycle completion pulse
//   resp_rdata seq -> master  read data, valid with resp_valid after a read
//
// Modports: master (request issuer), slave (mem_sequencer).
interface mem_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        resp_valid;
   logic [15:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer -- single-word read/write sequencer in front of the SRAM
// interface block (MAR/MDR pair with a 16-bit SRAM behind it).
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          mem_sequencer_if.slave request/response handshake
//   reg_load_ub  load upper byte of selected register (MAR/MDR)
//   reg_load_lb  load lower byte of selected register
//   reg_sel      1 = MAR, 0 = MDR
//   read         capture SRAM data into MDR at this edge
//   write        SRAM write strobe
//   reg_d        register load data
//   reg_q        selected register contents
//
// Parameter WAIT_CYCLES (1..15): SRAM hold cycles before capture / write strobe length.
// Optional macro MEM_SEQ_RMW_EN: partial byte writes become read-modify-write,
// and a write with no byte enabled completes without touching the SRAM.
module mem_sequencer #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   mem_sequencer_if.slave bus,
   output logic        reg_load_ub,
   output logic        reg_load_lb,
   output logic        reg_sel,
   output logic        read,
   output logic        write,
   output logic [15:0] reg_d,
   input  logic [15:0] reg_q
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_DATA, ST_WAIT, ST_READ, ST_LATCH, ST_WRITE, ST_RESP
`ifdef MEM_SEQ_RMW_EN
      , ST_MERGE
`endif
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        we_q;
   logic [15:0] wdata_q;
   logic        accept;
   logic        full_write;

   logic        ready_n, resp_valid_n, load_ub_n, load_lb_n, sel_n, read_n, write_n;
   logic [15:0] reg_d_n;

`ifdef MEM_SEQ_RMW_EN
   logic [1:0]  be_q;
   assign full_write = we_q && (be_q == 2'b11);
`else
   assign full_write = we_q;
`endif

   assign accept = bus.req_valid && bus.req_ready;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ST_IDLE:
            if (accept) begin
`ifdef MEM_SEQ_RMW_EN
               if (bus.req_we && bus.req_be == 2'b00) state_n = ST_RESP;
               else                                   state_n = ST_ADDR;
`else
               state_n = ST_ADDR;
`endif
            end
         ST_ADDR:
            if (full_write) begin
               state_n = ST_DATA;
            end else begin
               state_n = ST_WAIT;
               cnt_n   = WAIT_LOAD;
            end
         ST_DATA: begin
            state_n = ST_WRITE;
            cnt_n   = WAIT_LOAD;
         end
         ST_WAIT:
            if (cnt == 4'd0) state_n = ST_READ;
            else             cnt_n   = cnt - 4'd1;
         ST_READ:
`ifdef MEM_SEQ_RMW_EN
            // A write reaching READ is a partial write: merge the new lane into MDR.
            if (we_q) state_n = ST_MERGE;
            else      state_n = ST_LATCH;
         ST_MERGE: begin
            state_n = ST_WRITE;
            cnt_n   = WAIT_LOAD;
         end
`else
            state_n = ST_LATCH;
`endif
         ST_LATCH: state_n = ST_RESP;
         ST_WRITE:
            if (cnt == 4'd0) state_n = ST_RESP;
            else             cnt_n   = cnt - 4'd1;
         ST_RESP:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so every output
   // is a flop whose value matches the state it is present in.
   always_comb begin
      ready_n      = 1'b0;
      resp_valid_n = 1'b0;
      load_ub_n    = 1'b0;
      load_lb_n    = 1'b0;
      sel_n        = 1'b0;
      read_n       = 1'b0;
      write_n      = 1'b0;
      reg_d_n      = '0;
      case (state_n)
         ST_IDLE: ready_n = 1'b1;
         ST_ADDR: begin
            // ADDR is only entered from the accept edge, so the address comes straight from the bus.
            sel_n     = 1'b1;
            load_ub_n = 1'b1;
            load_lb_n = 1'b1;
            reg_d_n   = bus.req_addr;
         end
         ST_DATA: begin
            load_ub_n = 1'b1;
            load_lb_n = 1'b1;
            reg_d_n   = wdata_q;
         end
`ifdef MEM_SEQ_RMW_EN
         ST_MERGE: begin
            load_ub_n = be_q[1];
            load_lb_n = be_q[0];
            reg_d_n   = wdata_q;
         end
`endif
         ST_READ:  read_n       = 1'b1;
         ST_WRITE: write_n      = 1'b1;
         ST_RESP:  resp_valid_n = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
`ifdef MEM_SEQ_RMW_EN
         be_q           <= '0;
`endif
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         reg_load_ub    <= 1'b0;
         reg_load_lb    <= 1'b0;
         reg_sel        <= 1'b0;
         read           <= 1'b0;
         write          <= 1'b0;
         reg_d          <= '0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         if (state == ST_IDLE && accept) begin
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
`ifdef MEM_SEQ_RMW_EN
            be_q    <= bus.req_be;
`endif
         end
         if (state == ST_LATCH) bus.resp_rdata <= reg_q;
         bus.req_ready  <= ready_n;
         bus.resp_valid <= resp_valid_n;
         reg_load_ub    <= load_ub_n;
         reg_load_lb    <= load_lb_n;
         reg_sel        <= sel_n;
         read           <= read_n;
         write          <= write_n;
         reg_d          <= reg_d_n;
      end
   end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer -- directed bench for mem_sequencer.
// Two instances (WAIT_CYCLES=2 and 4) share the same request stimulus, each with
// its own MAR/MDR + SRAM model. Build with or without MEM_SEQ_RMW_EN.
module tb_mem_sequencer;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic        valid = 1'b0;
   logic        we    = 1'b0;
   logic [15:0] addr  = '0;
   logic [15:0] wdata = '0;
   logic [1:0]  be    = 2'b11;

   mem_sequencer_if bus0 ();
   mem_sequencer_if bus1 ();

   assign bus0.req_valid = valid;
   assign bus0.req_we    = we;
   assign bus0.req_addr  = addr;
   assign bus0.req_wdata = wdata;
   assign bus0.req_be    = be;
   assign bus1.req_valid = valid;
   assign bus1.req_we    = we;
   assign bus1.req_addr  = addr;
   assign bus1.req_wdata = wdata;
   assign bus1.req_be    = be;

   logic        ld_ub0, ld_lb0, sel0, rd0, wr0;
   logic [15:0] d0, q0;
   logic        ld_ub1, ld_lb1, sel1, rd1, wr1;
   logic [15:0] d1, q1;

   mem_sequencer #(.WAIT_CYCLES(2)) dut0 (
      .clock(clock), .reset_n(reset_n), .bus(bus0),
      .reg_load_ub(ld_ub0), .reg_load_lb(ld_lb0), .reg_sel(sel0),
      .read(rd0), .write(wr0), .reg_d(d0), .reg_q(q0)
   );

   mem_sequencer #(.WAIT_CYCLES(4)) dut1 (
      .clock(clock), .reset_n(reset_n), .bus(bus1),
      .reg_load_ub(ld_ub1), .reg_load_lb(ld_lb1), .reg_sel(sel1),
      .read(rd1), .write(wr1), .reg_d(d1), .reg_q(q1)
   );

   // SRAM block models: byte-masked MAR/MDR loads, read capture, write strobe.
   logic [15:0] mar0, mdr0, mar1, mdr1;
   logic [15:0] mem0 [256];
   logic [15:0] mem1 [256];
   logic        pl_en   = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [15:0] pl_data = '0;

   always @(posedge clock) begin
      if (ld_ub0 &&  sel0) mar0[15:8] <= d0[15:8];
      if (ld_lb0 &&  sel0) mar0[7:0]  <= d0[7:0];
      if (ld_ub0 && !sel0) mdr0[15:8] <= d0[15:8];
      if (ld_lb0 && !sel0) mdr0[7:0]  <= d0[7:0];
      if (rd0) mdr0 <= mem0[mar0[7:0]];
      if (wr0) mem0[mar0[7:0]] <= mdr0;
      if (pl_en) mem0[pl_addr] <= pl_data;
   end
   assign q0 = sel0 ? mar0 : mdr0;

   always @(posedge clock) begin
      if (ld_ub1 &&  sel1) mar1[15:8] <= d1[15:8];
      if (ld_lb1 &&  sel1) mar1[7:0]  <= d1[7:0];
      if (ld_ub1 && !sel1) mdr1[15:8] <= d1[15:8];
      if (ld_lb1 && !sel1) mdr1[7:0]  <= d1[7:0];
      if (rd1) mdr1 <= mem1[mar1[7:0]];
      if (wr1) mem1[mar1[7:0]] <= mdr1;
      if (pl_en) mem1[pl_addr] <= pl_data;
   end
   assign q1 = sel1 ? mar1 : mdr1;

   logic [31:0] outs0;
   assign outs0 = {8'd0, bus0.req_ready, bus0.resp_valid, ld_ub0, ld_lb0, sel0, rd0, wr0,
                   |d0, bus0.resp_rdata};

   // Monitors, sampled on the falling edge.
   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int unsigned acc0 = 0, resp0 = 0, wrc0 = 0, ovl0 = 0, lderr0 = 0, rdyerr0 = 0;
   int unsigned last_resp0 = 0, last_rd0 = 0;
   logic [15:0] rdata0 = '0, wmar0 = '0;
   bit          busy0 = 1'b0;
   always @(negedge clock) begin
      if (busy0 && bus0.req_ready) rdyerr0++;
      if (rd0 && wr0) ovl0++;
      if ((rd0 || wr0) && (ld_ub0 || ld_lb0)) lderr0++;
      if (wr0) begin wrc0++; wmar0 = mar0; end
      if (rd0) last_rd0 = cyc;
      if (bus0.resp_valid) begin resp0++; last_resp0 = cyc; rdata0 = bus0.resp_rdata; busy0 = 1'b0; end
      if (bus0.req_valid && bus0.req_ready) begin acc0++; busy0 = 1'b1; end
      if (!reset_n) busy0 = 1'b0;
   end

   int unsigned resp1 = 0, wrc1 = 0, ovl1 = 0, lderr1 = 0, rdyerr1 = 0;
   int unsigned last_resp1 = 0, last_rd1 = 0;
   logic [15:0] rdata1 = '0;
   bit          busy1 = 1'b0;
   always @(negedge clock) begin
      if (busy1 && bus1.req_ready) rdyerr1++;
      if (rd1 && wr1) ovl1++;
      if ((rd1 || wr1) && (ld_ub1 || ld_lb1)) lderr1++;
      if (wr1) wrc1++;
      if (rd1) last_rd1 = cyc;
      if (bus1.resp_valid) begin resp1++; last_resp1 = cyc; rdata1 = bus1.resp_rdata; busy1 = 1'b0; end
      if (bus1.req_valid && bus1.req_ready) busy1 = 1'b1;
      if (!reset_n) busy1 = 1'b0;
   end

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         if (bus0.req_ready && bus1.req_ready) return;
      end
      chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] dt);
      pl_en = 1'b1; pl_addr = a; pl_data = dt;
      @(posedge clock); #1;
      pl_en = 1'b0;
   endtask

   // Issue one request to both instances; latencies are in cycles with the
   // accept edge ending cycle 0.
   task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] dt,
                         input logic [1:0] b, output int lat0, output int lat1,
                         output int wn0, output int wn1, output int rdl0, output int rdl1);
      int unsigned s_r0, s_r1, s_w0, s_w1, base;
      bit done;
      wait_ready();
      s_r0 = resp0; s_r1 = resp1; s_w0 = wrc0; s_w1 = wrc1;
      valid = 1'b1; we = w; addr = a; wdata = dt; be = b;
      @(posedge clock); #1;
      valid = 1'b0;
      base = cyc;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         if (resp0 > s_r0 && resp1 > s_r1) done = 1'b1;
         else begin @(posedge clock); #1; end
      end
      if (!done) chk("resp_timeout", 32'd0, 32'd1);
      lat0 = int'(last_resp0) - int'(base) + 1;
      lat1 = int'(last_resp1) - int'(base) + 1;
      rdl0 = int'(last_rd0) - int'(base) + 1;
      rdl1 = int'(last_rd1) - int'(base) + 1;
      wn0  = int'(wrc0 - s_w0);
      wn1  = int'(wrc1 - s_w1);
   endtask

   task automatic set_b2b(input int k);
      case (k)
         0: begin we = 1'b1; addr = 16'h0020; wdata = 16'h1111; end
         1: begin we = 1'b1; addr = 16'h0021; wdata = 16'h2222; end
         default: begin we = 1'b0; addr = 16'h0020; wdata = 16'h0000; end
      endcase
      be = 2'b11;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int l0, l1, w0, w1, r0, r1;
      int unsigned sa, sr;
      int k;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_outputs", outs0, 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("ready_after_rst", {31'd0, bus0.req_ready}, 32'd1);

      // Full write then read back
      do_req(1'b1, 16'h00A5, 16'h1234, 2'b11, l0, l1, w0, w1, r0, r1);
      chk("wr_lat_w2", l0, 5);
      chk("wr_len_w2", w0, 2);
      chk("wr_mar_w2", {16'd0, wmar0}, 32'h00A5);
      chk("wr_mem_w2", {16'd0, mem0[8'hA5]}, 32'h1234);
      chk("wr_lat_w4", l1, 7);
      chk("wr_len_w4", w1, 4);

      do_req(1'b0, 16'h00A5, 16'h0000, 2'b11, l0, l1, w0, w1, r0, r1);
      chk("rd_lat_w2", l0, 6);
      chk("rd_strobe_w2", r0, 4);
      chk("rd_data_w2", {16'd0, rdata0}, 32'h1234);
      chk("rd_lat_w4", l1, 8);

      // WAIT_CYCLES=4 read of a preloaded word
      preload(8'h30, 16'hBEEF);
      do_req(1'b0, 16'h0030, 16'h0000, 2'b00, l0, l1, w0, w1, r0, r1);
      chk("rd_strobe_w4", r1, 6);
      chk("rd_lat_w4b", l1, 8);
      chk("rd_data_w4", {16'd0, rdata1}, 32'hBEEF);
      chk("rd_data_w2b", {16'd0, rdata0}, 32'hBEEF);

      // Three back-to-back requests with req_valid held high
      wait_ready();
      sa = acc0; sr = resp0; k = 0;
      set_b2b(0);
      valid = 1'b1;
      for (int i = 0; i < 100 && k < 3; i++) begin
         @(posedge clock); #1;
         if (int'(acc0 - sa) > k) begin
            k++;
            if (k < 3) set_b2b(k);
            else       valid = 1'b0;
         end
      end
      valid = 1'b0;
      if (k < 3) chk("b2b_accept_timeout", k, 3);
      for (int i = 0; i < 60 && (resp0 - sr) < 3; i++) begin
         @(posedge clock); #1;
      end
      repeat (4) @(posedge clock);
      #1;
      chk("b2b_accepts", acc0 - sa, 3);
      chk("b2b_resps", resp0 - sr, 3);
      chk("b2b_mem20", {16'd0, mem0[8'h20]}, 32'h1111);
      chk("b2b_mem21", {16'd0, mem0[8'h21]}, 32'h2222);
      chk("b2b_rdata", {16'd0, rdata0}, 32'h1111);

      // Asynchronous reset during the second WRITE cycle
      wait_ready();
      sr = resp0;
      valid = 1'b1; we = 1'b1; addr = 16'h0040; wdata = 16'h5A5A; be = 2'b11;
      @(posedge clock); #1;
      valid = 1'b0;
      repeat (3) @(posedge clock);
      #3;
      chk("wr_before_rst", {31'd0, wr0}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_async_wr", {31'd0, wr0}, 32'd0);
      chk("rst_async_outs", outs0, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("no_resp_after_rst", resp0 - sr, 0);
      do_req(1'b0, 16'h00A5, 16'h0000, 2'b11, l0, l1, w0, w1, r0, r1);
      chk("post_rst_lat", l0, 6);
      chk("post_rst_data", {16'd0, rdata0}, 32'h1234);

      // Byte-enable handling
`ifdef MEM_SEQ_RMW_EN
      preload(8'h10, 16'hABCD);
      do_req(1'b1, 16'h0010, 16'h0077, 2'b01, l0, l1, w0, w1, r0, r1);
      chk("rmw_lo_mem", {16'd0, mem0[8'h10]}, 32'hAB77);
      chk("rmw_lo_lat_w2", l0, 8);
      chk("rmw_lo_lat_w4", l1, 12);
      chk("rmw_lo_len", w0, 2);
      preload(8'h10, 16'hABCD);
      do_req(1'b1, 16'h0010, 16'h5500, 2'b10, l0, l1, w0, w1, r0, r1);
      chk("rmw_hi_mem_w2", {16'd0, mem0[8'h10]}, 32'h55CD);
      chk("rmw_hi_mem_w4", {16'd0, mem1[8'h10]}, 32'h55CD);
      do_req(1'b1, 16'h0010, 16'h9999, 2'b00, l0, l1, w0, w1, r0, r1);
      chk("be00_lat", l0, 1);
      chk("be00_no_strobe", w0, 0);
      chk("be00_mem", {16'd0, mem0[8'h10]}, 32'h55CD);
`else
      preload(8'h10, 16'hABCD);
      do_req(1'b1, 16'h0010, 16'h0077, 2'b01, l0, l1, w0, w1, r0, r1);
      chk("be_ignored_mem", {16'd0, mem0[8'h10]}, 32'h0077);
      chk("be_ignored_lat", l0, 5);
      chk("be_ignored_len", w0, 2);
`endif
      chk("rdata_hold", {16'd0, bus0.resp_rdata}, 32'h1234);

      // Invariants accumulated over the whole run
      chk("rw_overlap", ovl0 + ovl1, 0);
      chk("load_during_strobe", lderr0 + lderr1, 0);
      chk("ready_while_busy", rdyerr0 + rdyerr1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Bus-side memory access sequencer that sits directly upstream of the SRAM interface block (MAR/MDR register pair with the external 16-bit SRAM behind it).
- Accepts single-word read/write requests over a valid/ready handshake.
- Drives the SRAM block's register-load, register-select, read and write controls through the MAR-load, MDR-load, wait and capture phases with a fixed number of SRAM wait cycles.
- Returns read data and completion on a one-cycle response pulse.

Parameters:
- WAIT_CYCLES, 2, cycles the SRAM address/data is held before capture (read) or with write asserted (write); legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  word address.
- req_wdata  in  16  write data.
- req_be  in  2  byte enables {upper, lower}; used only with the optional feature.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  16  read data, valid while resp_valid is high after a read.
- reg_load_ub  out  1  to SRAM block: load the upper byte of the selected register.
- reg_load_lb  out  1  to SRAM block: load the lower byte of the selected register.
- reg_sel  out  1  to SRAM block: 1 = MAR, 0 = MDR.
- read  out  1  to SRAM block: capture SRAM data into MDR at this edge.
- write  out  1  to SRAM block: SRAM write strobe (active high).
- reg_d  out  16  to SRAM block: register load data.
- reg_q  in  16  from SRAM block: selected register contents.

Behaviour:
- All outputs come directly from flops. Reset clears every output to 0 immediately, asynchronously, and forces IDLE. This includes write dropping mid-write. No partial response is issued after reset.
- The values listed per state are the values present during that state.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted at an edge where req_valid & req_ready. req_we, req_addr, req_wdata and req_be are latched at that edge.
  - Request inputs are ignored in all other states.
- FSM states: IDLE, ADDR, DATA, WAIT, READ, LATCH, WRITE, RESP (plus MERGE with the optional feature).
  - ADDR: reg_sel=1, reg_load_ub=reg_load_lb=1, reg_d=addr. Loads MAR.
  - Read path: ADDR -> WAIT (WAIT_CYCLES cycles, all controls 0, reg_sel=0) -> READ (read=1 for exactly one cycle, loads 0) -> LATCH (reg_sel=0; resp_rdata <= reg_q at the end of this cycle) -> RESP.
  - Write path: ADDR -> DATA (reg_sel=0, both loads=1, reg_d=wdata) -> WRITE (write=1 for exactly WAIT_CYCLES cycles) -> RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- Latency, counting the accept edge as the end of cycle 0:
  - Read: resp_valid high in cycle WAIT_CYCLES+4 (6 at default).
  - Write: resp_valid high in cycle WAIT_CYCLES+3 (5 at default).
  - Minimum request spacing is one IDLE cycle after RESP.
- Invariants:
  - read and write are never high together.
  - reg_load_ub and reg_load_lb are 0 whenever read or write is 1.
  - MAR is loaded only in ADDR, so the address is stable for the whole of WAIT, READ, WRITE and RESP.
  - write=0 in the cycle before and the cycle after every write strobe.
- resp_rdata resets to 0. It updates only in LATCH and holds across writes.
- reg_d = 0 outside ADDR, DATA and MERGE.
- The wait counter is 4 bits. It loads WAIT_CYCLES-1 on entry to WAIT or WRITE and exits at 0, so there is no wrap.

Optional Feature:
- Macro: MEM_SEQ_RMW_EN.
- Defined: byte writes are done by read-modify-write.
  - Write with req_be=2'b11: normal write path.
  - Write with req_be=2'b01 or 2'b10: ADDR -> WAIT -> READ (old word into MDR) -> MERGE -> WRITE -> RESP. MERGE has reg_sel=0, reg_load_ub=be[1], reg_load_lb=be[0], reg_d=wdata, so the SRAM block's masked load merges only the enabled lane. Latency is 2*WAIT_CYCLES+4.
  - Write with req_be=2'b00: ACCEPT -> RESP directly, with no SRAM activity (resp_valid in cycle 1).
  - Reads ignore req_be.
- Undefined: req_be is ignored, all writes are full-word, and MERGE does not exist.

Test Plan:
- The bench uses the SRAM block plus a behavioural SRAM model, with WAIT_CYCLES=2.
- Write 0x1234 to 0x00A5, then read 0x00A5 -> write=1 for exactly 2 cycles with MAR=0x00A5; write resp_valid in cycle 5; read resp_valid in cycle 6 with resp_rdata=0x1234.
- Hold req_valid=1 continuously with three back-to-back requests -> req_ready=0 from accept through RESP; exactly three accepts; no request lost or duplicated; read/write never overlap.
- Drop reset_n during the second WRITE cycle -> write=0 and all outputs 0 without waiting for a clock edge; no resp_valid; the next request after release completes normally.
- MEM_SEQ_RMW_EN defined, memory[0x0010]=0xABCD: write 0x0077 with be=2'b01 -> memory=0xAB77, resp in cycle 8; be=2'b10 with 0x5500 -> 0x55CD; be=2'b00 -> no write strobe, resp in cycle 1.
- MEM_SEQ_RMW_EN undefined: write 0x0077 with be=2'b01 to 0xABCD -> memory=0x0077.
- WAIT_CYCLES=4: read of 0xBEEF -> read strobe in cycle 6, resp_valid in cycle 8, rdata=0xBEEF; write strobe held 4 cycles.
